// File: rtl/fifo_enq_arbiter.sv
// Round-robin burst arbiter feeding one FIFO enqueue port from N_REQ requesters.
// Optional beat statistics counter is enabled by defining FIFO_ARB_STATS_EN.
module fifo_enq_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_enq,
  output logic [WIDTH-1:0]           fifo_enq_data,
`ifdef FIFO_ARB_STATS_EN
  output logic [31:0]                beat_count,
`endif
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0]  LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(N_REQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_r, state_s;
  logic [IDW-1:0] owner_r, owner_s;
  logic [IDW-1:0] rr_ptr_r, rr_ptr_s;
  logic [CW-1:0]  burst_cnt_r, burst_cnt_s;
  logic [IDW-1:0] pick_s;
  logic           found_s;
  logic           any_valid_s;
  logic           acc_s;
  logic           release_s;

  // First valid requester at or above rr_ptr, wrapping modulo N_REQ
  always_comb begin
    pick_s  = rr_ptr_r;
    found_s = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      pick_s  = (!found_s && req_valid[(int'(rr_ptr_r) + k) % N_REQ])
                ? IDW'((int'(rr_ptr_r) + k) % N_REQ) : pick_s;
      found_s = found_s | req_valid[(int'(rr_ptr_r) + k) % N_REQ];
    end
  end

  assign any_valid_s = |req_valid;
  assign acc_s       = (state_r == GRANT) && req_valid[owner_r] && !fifo_full;
  // A stalled owner keeps the grant; only a dropped valid or the final beat frees it
  assign release_s   = (state_r == GRANT) &&
                       ((acc_s && (burst_cnt_r == LAST_BEAT)) || !req_valid[owner_r]);

  // Next-state and register update logic
  always_comb begin
    state_s     = state_r;
    owner_s     = owner_r;
    rr_ptr_s    = rr_ptr_r;
    burst_cnt_s = burst_cnt_r;
    case (state_r)
      IDLE: begin
        if (any_valid_s) begin
          state_s     = GRANT;
          owner_s     = pick_s;
          burst_cnt_s = {CW{1'b0}};
        end else begin
          state_s     = IDLE;
        end
      end
      GRANT: begin
        if (acc_s) begin
          burst_cnt_s = burst_cnt_r + CW'(1);
        end else begin
          burst_cnt_s = burst_cnt_r;
        end
        if (release_s) begin
          state_s  = IDLE;
          rr_ptr_s = (owner_r == LAST_ID) ? {IDW{1'b0}} : owner_r + IDW'(1);
        end else begin
          state_s  = GRANT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, owner, pointer and burst counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      owner_r     <= {IDW{1'b0}};
      rr_ptr_r    <= {IDW{1'b0}};
      burst_cnt_r <= {CW{1'b0}};
    end else begin
      state_r     <= state_s;
      owner_r     <= owner_s;
      rr_ptr_r    <= rr_ptr_s;
      burst_cnt_r <= burst_cnt_s;
    end
  end

  assign busy          = (state_r == GRANT);
  assign grant_id      = owner_r;
  assign fifo_enq      = acc_s;
  assign req_ready     = {{(N_REQ-1){1'b0}}, acc_s} << owner_r;
  assign fifo_enq_data = req_data[owner_r*WIDTH +: WIDTH];

`ifdef FIFO_ARB_STATS_EN
  // Accepted-beat counter, wraps modulo 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count <= 32'd0;
    end else if (acc_s) begin
      beat_count <= beat_count + 32'd1;
    end else begin
      beat_count <= beat_count;
    end
  end
`endif

endmodule

// File: doc/fifo_enq_arbiter.md
FIFO_ENQ_ARBITER -- requirements
Module: fifo_enq_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 16, giving the data width, matching the FIFO enq_data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, giving the maximum beats per grant (1..16).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, N_REQ bits: bit i means requester i has a beat to send.
REQ-007 SHALL have port req_data, input, N_REQ*WIDTH bits: requester i data occupies bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_ready, output, N_REQ bits: bit i means requester i's beat is accepted this cycle.
REQ-009 SHALL have port fifo_full, input, 1 bit, driven from the FIFO full flag.
REQ-010 SHALL have port fifo_enq, output, 1 bit, driving the FIFO enq input.
REQ-011 SHALL have port fifo_enq_data, output, WIDTH bits, driving the FIFO enq_data input.
REQ-012 SHALL have port grant_id, output, $clog2(N_REQ) bits: the index of the current owner.
REQ-013 SHALL have port busy, output, 1 bit: high while in GRANT.

Function
REQ-014 SHALL implement the FSM states IDLE and GRANT, with registered state, owner, rr_ptr and burst_cnt.
REQ-015 SHALL, in IDLE with any req_valid high, select the first valid index searching upward from rr_ptr (modulo N_REQ), latch it as owner, clear burst_cnt, and enter GRANT on the next edge.
REQ-016 SHALL, in IDLE with no req_valid high, stay in IDLE and hold all registers.
REQ-017 SHALL drive, combinationally, a beat accept signal acc = busy && req_valid[owner] && !fifo_full.
REQ-018 SHALL drive fifo_enq = acc, req_ready = acc one-hot at the owner index, and fifo_enq_data = the owner's req_data slice.
REQ-019 SHALL never assert fifo_enq while fifo_full is high; in that case GRANT holds and burst_cnt is unchanged.
REQ-020 SHALL increment burst_cnt on each acc.
REQ-021 SHALL release the grant (GRANT->IDLE) when acc occurs with burst_cnt == MAX_BURST-1, or when req_valid[owner] is low.
REQ-022 SHALL, on release, set rr_ptr = owner+1, wrapping from N_REQ-1 to 0.
REQ-023 SHALL insert one IDLE cycle between grants, giving an arbitration latency of 1 cycle.
REQ-024 SHALL hold grant_id stable throughout GRANT; grant_id is don't-care in IDLE but shows the registered owner.

Reset
REQ-025 SHALL, while reset is high, immediately force state=IDLE, owner=0, rr_ptr=0, burst_cnt=0, giving busy=0, fifo_enq=0, req_ready=0 and grant_id=0.
REQ-026 SHALL drop any in-progress burst on reset mid-burst; a partially sent burst is not resumed.

Configuration
REQ-027 SHALL, when macro FIFO_ARB_STATS_EN is defined, add output beat_count (32 bits): a count of acc cycles, reset to 0, wrapping modulo 2^32.
REQ-028 SHALL, when FIFO_ARB_STATS_EN is undefined, omit the beat_count port and counter entirely, with all other behaviour identical.

Verification
REQ-029 SHALL cover single requester: req_valid=0001 held for 6 beats, MAX_BURST=4 -> 4 beats accepted, 1 IDLE cycle, then 2 beats; fifo_enq is high for 6 cycles in total.
REQ-030 SHALL cover round-robin: all valid=1111, each sending 1 beat then dropping valid -> grant order 0,1,2,3, with rr_ptr wrapping to 0.
REQ-031 SHALL cover FIFO full: fifo_full=1 for 3 cycles mid-burst -> fifo_enq=0 and req_ready=0 for those 3 cycles, and burst_cnt resumes without beat loss.
REQ-032 SHALL cover early release: owner 2 drops valid after 2 beats while requester 3 is valid -> release, IDLE, then grant_id=3.
REQ-033 SHALL cover reset mid-burst: reset pulsed after 2 beats -> outputs go to 0 asynchronously, then the next grant starts searching from index 0.
REQ-034 SHALL cover stats with FIFO_ARB_STATS_EN: 10 accepted beats -> beat_count=10; with the macro undefined, the bench builds without beat_count.
